// File: rtl/wmem_app_arb_pkg.sv
// Shared constants for the wide-memory application-port arbiter.
// FSM encodings are kept as plain constants for compatibility with older users.
package wmem_app_arb_pkg;

  localparam logic [0:0] WMEM_ARB_INIT = 1'b0;
  localparam logic [0:0] WMEM_ARB_RUN  = 1'b1;

  // Number of entries in the read-tag FIFO, i.e. the outstanding-read credit limit.
  function automatic int unsigned tag_fifo_depth(int unsigned tag_nbits);
    return 32'd1 << tag_nbits;
  endfunction

endpackage

// File: rtl/wmem_rr_arb.sv
// Round-robin arbiter: search upward from the pointer with wrap-around,
// pointer moves to one past the winner on every grant.
module wmem_rr_arb #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned NREQ_NBITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  input  logic [NREQ-1:0]       req_i,
  output logic [NREQ-1:0]       gnt_o,
  output logic                  valid_o,
  output logic [NREQ_NBITS-1:0] winner_o
);

  logic [NREQ_NBITS-1:0] ptr_q, ptr_d;
  logic [NREQ_NBITS-1:0] idx;

  always_comb begin
    gnt_o    = '0;
    valid_o  = 1'b0;
    winner_o = '0;
    idx      = ptr_q;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (en_i && !valid_o && req_i[idx]) begin
        valid_o    = 1'b1;
        gnt_o[idx] = 1'b1;
        winner_o   = idx;
      end
      idx = (idx == NREQ_NBITS'(NREQ - 1)) ? '0 : idx + 1'b1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (valid_o) begin
      ptr_d = (winner_o == NREQ_NBITS'(NREQ - 1)) ? '0 : winner_o + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/wmem_app_arb.sv
// Shares the application port of a 1R1W wide memory among NREQ requesters, routes
// in-order read acks through a tag FIFO, and zero-fills the memory on reset/command.
module wmem_app_arb
  import wmem_app_arb_pkg::*;
#(
  parameter int unsigned WIDTH       = 40,
  parameter int unsigned DEPTH_NBITS = 10,
  parameter int unsigned NREQ        = 4,
  parameter int unsigned NREQ_NBITS  = 2,
  parameter int unsigned TAG_NBITS   = 3,
  parameter logic        INIT_EN     = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NREQ-1:0]             req_rd,
  input  logic [NREQ*DEPTH_NBITS-1:0] req_raddr,
  output logic [NREQ-1:0]             req_rd_gnt,
  input  logic [NREQ-1:0]             req_wr,
  input  logic [NREQ*DEPTH_NBITS-1:0] req_waddr,
  input  logic [NREQ*WIDTH-1:0]       req_wdata,
  output logic [NREQ-1:0]             req_wr_gnt,
  output logic [NREQ-1:0]             req_ack,
  output logic [WIDTH-1:0]            req_rdata,
  output logic                        mem_rd,
  output logic [DEPTH_NBITS-1:0]      mem_raddr,
  output logic                        mem_wr,
  output logic [DEPTH_NBITS-1:0]      mem_waddr,
  output logic [WIDTH-1:0]            mem_wdata,
  input  logic                        mem_ack,
  input  logic [WIDTH-1:0]            mem_rdata,
  input  logic                        init_start,
  output logic                        init_done,
  output logic                        err_ack
);

  localparam int unsigned TagDepth = tag_fifo_depth(TAG_NBITS);

  logic [0:0]             state_q, state_d;
  logic [DEPTH_NBITS-1:0] init_addr_q, init_addr_d;
  logic                   init_done_q, init_done_d;
  logic                   run_en;

  logic [NREQ_NBITS-1:0]  tag_mem_q [TagDepth];
  logic [TAG_NBITS-1:0]   tag_wptr_q, tag_rptr_q;
  logic [TAG_NBITS:0]     tag_cnt_q;
  logic                   tag_push, tag_pop, rd_room;
  logic [NREQ_NBITS-1:0]  tag_head;

  logic                   rd_valid, wr_valid;
  logic [NREQ_NBITS-1:0]  rd_win, wr_win;

  logic                   mem_rd_q, mem_wr_q, mem_wr_d;
  logic [DEPTH_NBITS-1:0] mem_raddr_q, mem_raddr_d, mem_waddr_q, mem_waddr_d;
  logic [WIDTH-1:0]       mem_wdata_q, mem_wdata_d;
  logic [NREQ-1:0]        req_ack_q, req_ack_d;
  logic [WIDTH-1:0]       req_rdata_q, req_rdata_d;
  logic                   err_ack_q;

  // Grants wait for init_done so no request slips in on the first RUN cycle.
  assign run_en   = (state_q == WMEM_ARB_RUN) && init_done_q;
  assign tag_pop  = mem_ack && (tag_cnt_q != '0);
  assign rd_room  = !tag_cnt_q[TAG_NBITS] || tag_pop;
  assign tag_push = rd_valid;
  assign tag_head = tag_mem_q[tag_rptr_q];

  wmem_rr_arb #(
    .NREQ      (NREQ),
    .NREQ_NBITS(NREQ_NBITS)
  ) u_rd_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (run_en && rd_room),
    .req_i   (req_rd),
    .gnt_o   (req_rd_gnt),
    .valid_o (rd_valid),
    .winner_o(rd_win)
  );

  wmem_rr_arb #(
    .NREQ      (NREQ),
    .NREQ_NBITS(NREQ_NBITS)
  ) u_wr_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (run_en),
    .req_i   (req_wr),
    .gnt_o   (req_wr_gnt),
    .valid_o (wr_valid),
    .winner_o(wr_win)
  );

  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    init_done_d = init_done_q;
    unique case (state_q)
      WMEM_ARB_INIT: begin
        init_done_d = 1'b0;
        init_addr_d = init_addr_q + 1'b1;
        if (init_addr_q == '1) state_d = WMEM_ARB_RUN;
      end
      default: begin
        init_done_d = 1'b1;
        if (init_start) begin
          state_d     = WMEM_ARB_INIT;
          init_addr_d = '0;
          init_done_d = 1'b0;
        end
      end
    endcase
  end

  always_comb begin
    mem_raddr_d = rd_valid ? req_raddr[32'(rd_win) * DEPTH_NBITS +: DEPTH_NBITS] : mem_raddr_q;
    mem_wr_d    = wr_valid;
    mem_waddr_d = mem_waddr_q;
    mem_wdata_d = mem_wdata_q;
    if (state_q == WMEM_ARB_INIT) begin
      mem_wr_d    = 1'b1;
      mem_waddr_d = init_addr_q;
      mem_wdata_d = '0;
    end else if (wr_valid) begin
      mem_waddr_d = req_waddr[32'(wr_win) * DEPTH_NBITS +: DEPTH_NBITS];
      mem_wdata_d = req_wdata[32'(wr_win) * WIDTH +: WIDTH];
    end
    req_ack_d   = '0;
    req_rdata_d = req_rdata_q;
    if (tag_pop) begin
      req_ack_d[tag_head] = 1'b1;
      req_rdata_d         = mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT_EN ? WMEM_ARB_INIT : WMEM_ARB_RUN;
      init_done_q <= !INIT_EN;
      init_addr_q <= '0;
      tag_wptr_q  <= '0;
      tag_rptr_q  <= '0;
      tag_cnt_q   <= '0;
      mem_rd_q    <= 1'b0;
      mem_raddr_q <= '0;
      mem_wr_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      req_ack_q   <= '0;
      req_rdata_q <= '0;
      err_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_done_q <= init_done_d;
      init_addr_q <= init_addr_d;
      if (tag_push) tag_wptr_q <= tag_wptr_q + 1'b1;
      if (tag_pop)  tag_rptr_q <= tag_rptr_q + 1'b1;
      unique case ({tag_push, tag_pop})
        2'b10:   tag_cnt_q <= tag_cnt_q + 1'b1;
        2'b01:   tag_cnt_q <= tag_cnt_q - 1'b1;
        default: tag_cnt_q <= tag_cnt_q;
      endcase
      mem_rd_q    <= rd_valid;
      mem_raddr_q <= mem_raddr_d;
      mem_wr_q    <= mem_wr_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdata_q <= mem_wdata_d;
      req_ack_q   <= req_ack_d;
      req_rdata_q <= req_rdata_d;
      err_ack_q   <= err_ack_q | (mem_ack && (tag_cnt_q == '0));
    end
  end

  // Tag storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (tag_push) tag_mem_q[tag_wptr_q] <= rd_win;
  end

  assign mem_rd    = mem_rd_q;
  assign mem_raddr = mem_raddr_q;
  assign mem_wr    = mem_wr_q;
  assign mem_waddr = mem_waddr_q;
  assign mem_wdata = mem_wdata_q;
  assign req_ack   = req_ack_q;
  assign req_rdata = req_rdata_q;
  assign init_done = init_done_q;
  assign err_ack   = err_ack_q;

endmodule

// File: tb/tb_wmem_app_arb.sv
// Scoreboard bench for wmem_app_arb: behavioural memory, expected read data queued at
// grant time and compared when the routed ack appears.
module tb_wmem_app_arb;

  localparam int W = 40;
  localparam int D = 10;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]   req_rd, req_wr, req_rd_gnt, req_wr_gnt, req_ack;
  logic [N*D-1:0] req_raddr, req_waddr;
  logic [N*W-1:0] req_wdata;
  logic [W-1:0]   req_rdata, mem_wdata, mem_rdata;
  logic [D-1:0]   mem_raddr, mem_waddr;
  logic           mem_rd, mem_wr, mem_ack, init_start, init_done, err_ack;

  wmem_app_arb #(
    .WIDTH(W), .DEPTH_NBITS(D), .NREQ(N), .NREQ_NBITS(2), .TAG_NBITS(3), .INIT_EN(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_rd(req_rd), .req_raddr(req_raddr), .req_rd_gnt(req_rd_gnt),
    .req_wr(req_wr), .req_waddr(req_waddr), .req_wdata(req_wdata), .req_wr_gnt(req_wr_gnt),
    .req_ack(req_ack), .req_rdata(req_rdata),
    .mem_rd(mem_rd), .mem_raddr(mem_raddr),
    .mem_wr(mem_wr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .init_start(init_start), .init_done(init_done), .err_ack(err_ack)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Behavioural memory: read-before-write at the same edge, acks in issue order.
  logic [W-1:0] mdl_mem [1<<D];
  logic [W-1:0] pend [$];
  logic stall = 1'b0, inject = 1'b0, plus100 = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend.delete();
      mem_ack   <= 1'b0;
      mem_rdata <= '0;
    end else begin
      if (mem_rd) pend.push_back(plus100 ? W'(mem_raddr) + W'(100) : mdl_mem[mem_raddr]);
      if (mem_wr) mdl_mem[mem_waddr] = mem_wdata;
      if (inject) begin
        mem_ack   <= 1'b1;
        mem_rdata <= W'(40'hDEAD);
      end else if (!stall && pend.size() > 0) begin
        mem_ack   <= 1'b1;
        mem_rdata <= pend.pop_front();
      end else begin
        mem_ack   <= 1'b0;
      end
    end
  end

  typedef struct packed {
    logic [N-1:0] ack;
    logic [W-1:0] data;
  } exp_t;

  exp_t         sb [$];
  logic [W-1:0] ref_mem [1<<D];
  logic         rd_prev = 1'b0, wr_prev = 1'b0;
  logic [D-1:0] rd_addr_prev, wr_addr_prev;
  logic [W-1:0] wr_data_prev;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      rd_prev = 1'b0;
      wr_prev = 1'b0;
    end else begin
      exp_t         e;
      logic [D-1:0] a;
      logic [W-1:0] d;
      if (rd_prev || mem_rd) begin
        check("mem_rd_after_gnt", mem_rd, rd_prev);
        if (rd_prev) check("mem_raddr", mem_raddr, rd_addr_prev);
      end
      if (wr_prev) begin
        check("mem_wr_after_gnt", mem_wr, 1);
        check("mem_waddr", mem_waddr, wr_addr_prev);
        check("mem_wdata", mem_wdata, wr_data_prev);
      end
      if (req_ack != '0) begin
        if (sb.size() == 0) begin
          check("ack_unexpected", req_ack, 0);
        end else begin
          e = sb.pop_front();
          check("ack_id", req_ack, e.ack);
          check("ack_data", req_rdata, e.data);
        end
      end
      rd_prev = 1'b0;
      wr_prev = 1'b0;
      if (req_rd_gnt != '0) begin
        check("rd_gnt_onehot", $onehot(req_rd_gnt), 1);
        for (int i = 0; i < N; i++) if (req_rd_gnt[i]) a = req_raddr[i*D +: D];
        e.ack  = req_rd_gnt;
        e.data = plus100 ? W'(a) + W'(100) : ref_mem[a];
        sb.push_back(e);
        rd_prev      = 1'b1;
        rd_addr_prev = a;
      end
      if (req_wr_gnt != '0) begin
        check("wr_gnt_onehot", $onehot(req_wr_gnt), 1);
        for (int i = 0; i < N; i++) begin
          if (req_wr_gnt[i]) begin
            a = req_waddr[i*D +: D];
            d = req_wdata[i*W +: W];
          end
        end
        ref_mem[a]   = d;
        wr_prev      = 1'b1;
        wr_addr_prev = a;
        wr_data_prev = d;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_ref();
    for (int i = 0; i < (1 << D); i++) ref_mem[i] = '0;
  endtask

  task automatic drain();
    int c = 0;
    while ((sb.size() != 0 || pend.size() != 0) && c < 200) begin
      tick();
      c++;
    end
    check("drain_done", (sb.size() == 0) && (pend.size() == 0), 1);
  endtask

  // Follows a zero-fill to completion; n_pre writes were already observed by the caller.
  task automatic wait_init(input int n_pre);
    int   n_wr = n_pre, seq_err = 0, gnt_seen = 0;
    logic last_prev = 1'b0, done_ok = 1'b0, seen_done = 1'b0;
    for (int c = 0; c < 1200 && !seen_done; c++) begin
      @(negedge clk);
      if (init_done) begin
        seen_done = 1'b1;
        done_ok   = last_prev;
      end else begin
        if (req_rd_gnt != '0 || req_wr_gnt != '0) gnt_seen++;
        last_prev = mem_wr && (mem_waddr == D'(1023));
        if (mem_wr) begin
          if (mem_waddr != D'(n_wr) || mem_wdata != '0) seq_err++;
          n_wr++;
        end
      end
    end
    check("init_done_rise", seen_done, 1);
    check("init_wr_count", n_wr, 1024);
    check("init_wr_seq", seq_err, 0);
    check("init_no_gnt", gnt_seen, 0);
    check("init_done_after_last_wr", done_ok, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] gnt_seq [8];
    logic [N-1:0] one, g;
    int ngr, n_pre, gs, seq;
    logic found;
    req_rd = '0; req_wr = '0; req_raddr = '0; req_waddr = '0; req_wdata = '0;
    init_start = 1'b0;
    one = N'(1);
    zero_ref();

    // Reset values, then zero-fill after release.
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", {mem_rd, mem_wr, req_ack, init_done, err_ack}, 0);
    check("rst_data", {req_rdata, mem_wdata}, 0);
    #2 rst_n = 1'b1;
    wait_init(0);

    // All four requesters held: strict rotation, data = raddr + 100.
    tick();
    plus100 = 1'b1;
    for (int i = 0; i < N; i++) req_raddr[i*D +: D] = D'(16 * i + 3);
    req_rd = '1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      gnt_seq[k] = req_rd_gnt;
      tick();
    end
    req_rd = '0;
    for (int k = 0; k < 8; k++) check($sformatf("rr_gnt%0d", k), gnt_seq[k], one << (k % N));
    drain();
    plus100 = 1'b0;

    // Stalled memory: credit limit of 8, first ack frees a grant in the same cycle.
    stall = 1'b1;
    req_raddr[2*D +: D] = D'(77);
    req_rd = 4'b0100;
    ngr = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req_rd_gnt[2]) ngr++;
      tick();
    end
    check("stall_gnt_count", ngr, 8);
    check("stall_gnt_zero", req_rd_gnt, 0);
    stall = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (mem_ack) begin
        found = 1'b1;
        check("ack_frees_gnt", req_rd_gnt, 4'b0100);
      end
    end
    check("ack_seen", found, 1);
    tick();
    req_rd = '0;
    drain();

    // Same-address write and read: old data first, new data one cycle later.
    req_waddr[1*D +: D] = D'(5);
    req_wdata[1*W +: W] = W'(40'hAB);
    req_raddr[3*D +: D] = D'(5);
    req_wr = 4'b0010;
    req_rd = 4'b1000;
    @(negedge clk);
    check("same_rd_gnt", req_rd_gnt, 4'b1000);
    check("same_wr_gnt", req_wr_gnt, 4'b0010);
    tick();
    req_wr = '0;
    @(negedge clk);
    check("same_both_issue", {mem_wr, mem_rd}, 2'b11);
    check("same_rd_gnt2", req_rd_gnt, 4'b1000);
    tick();
    req_rd = '0;
    drain();

    // Three reads in flight across an init_start.
    for (int i = 0; i < 3; i++) begin
      req_waddr[0 +: D] = D'(10 + i);
      req_wdata[0 +: W] = W'(40'h5500 + i);
      req_wr = 4'b0001;
      tick();
      req_wr = '0;
    end
    stall = 1'b1;
    req_raddr[0*D +: D] = D'(10);
    req_raddr[1*D +: D] = D'(11);
    req_raddr[3*D +: D] = D'(12);
    req_rd = 4'b1011;
    for (int c = 0; c < 10 && req_rd != '0; c++) begin
      @(negedge clk);
      g = req_rd_gnt;
      tick();
      req_rd = req_rd & ~g;
    end
    check("pre_init_outstanding", sb.size(), 3);
    init_start = 1'b1;
    zero_ref();
    tick();
    init_start = 1'b0;
    req_rd = 4'b0001;
    stall = 1'b0;
    n_pre = 0; gs = 0; seq = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 0) check("init_done_drop", init_done, 0);
      if (req_rd_gnt != '0) gs++;
      if (mem_wr) begin
        if (mem_waddr != D'(n_pre)) seq++;
        n_pre++;
      end
    end
    tick();
    req_rd = '0;
    check("init_gnt_stop", gs, 0);
    check("init_pre_seq", seq, 0);
    check("init_acks_routed", sb.size(), 0);
    wait_init(n_pre);

    // Spurious ack with nothing outstanding.
    drain();
    check("err_ack_clear", err_ack, 0);
    inject = 1'b1;
    tick();
    inject = 1'b0;
    repeat (3) tick();
    check("err_ack_set", err_ack, 1);
    repeat (10) tick();
    check("err_ack_sticky", err_ack, 1);

    // Asynchronous reset in the middle of a zero-fill.
    init_start = 1'b1;
    zero_ref();
    tick();
    init_start = 1'b0;
    repeat (100) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_async_ctrl", {mem_rd, mem_wr, req_ack, init_done, err_ack}, 0);
    check("rst_async_waddr", mem_waddr, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    wait_init(0);
    check("err_ack_after_rst", err_ack, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
